// File: rtl/alu_shift_pkg.sv
// Shared definitions for the multi-cycle shift/rotate unit: op codes, FSM states
// and the op-code legality check.
package alu_shift_pkg;

  typedef enum logic [2:0] {
    OP_SHL  = 3'd0,
    OP_SHR  = 3'd1,
    OP_SHRA = 3'd2,
    OP_ROL  = 3'd3,
    OP_ROR  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

endpackage

// File: rtl/alu_shift_unit_step.sv
// Combinational single-step helper: applies one op over 0..STEP bit positions.
// Sign fill for SHRA comes from the MSB of val_i.
module alu_shift_unit_step
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] val_i,
  input  op_e              op_i,
  input  logic [KW-1:0]    amt_i,
  output logic [WIDTH-1:0] res_o
);

  always_comb begin
    res_o = val_i;
    case (op_i)
      OP_SHL:  res_o = val_i << amt_i;
      OP_SHR:  res_o = val_i >> amt_i;
      OP_SHRA: res_o = $unsigned($signed(val_i) >>> amt_i);
      // A shift by WIDTH yields zero, so amt_i == 0 leaves the value intact.
      OP_ROL:  res_o = (val_i << amt_i) | (val_i >> (WIDTH - int'(amt_i)));
      OP_ROR:  res_o = (val_i >> amt_i) | (val_i << (WIDTH - int'(amt_i)));
      default: res_o = val_i;
    endcase
  end

endmodule

// File: rtl/alu_shift_unit.sv
// Multi-cycle shift/rotate unit: moves at most STEP bits per BUSY cycle and
// presents the held result with a start/done handshake.
//   state  | meaning
//   S_IDLE | waiting for start
//   S_BUSY | stepping the working register
//   S_DONE | done pulse; result valid, new start accepted
module alu_shift_unit
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SHAMT_W = $clog2(WIDTH),
  localparam int KW      = $clog2(STEP + 1)
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   data_input_i,
  input  logic [SHAMT_W-1:0] num_shifts_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               op_err_o,
  output logic [WIDTH-1:0]   data_output_o
);

  state_e             state_q;
  op_e                op_q;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [KW-1:0]      k;
  logic               ready_q, busy_q, done_q, err_q;
  logic               legal;

  always_comb begin
    k     = (int'(rem_q) >= STEP) ? KW'(STEP) : KW'(rem_q);
    rem_d = rem_q - SHAMT_W'(k);
    legal = op_legal(op_i);
  end

  alu_shift_unit_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .val_i (work_q),
    .op_i  (op_q),
    .amt_i (k),
    .res_o (work_d)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      op_q    <= OP_SHL;
      work_q  <= '0;
      rem_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_BUSY: begin
          work_q <= work_d;
          rem_q  <= rem_d;
          if (rem_d == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          if (start_i) begin
            op_q   <= op_e'(op_i);
            work_q <= data_input_i;
            rem_q  <= legal ? num_shifts_i : '0;
            err_q  <= ~legal;
            // Zero amount or illegal op skips BUSY and passes the operand through.
            if (num_shifts_i == '0 || !legal) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              state_q <= S_BUSY;
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign ready_o       = ready_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign op_err_o      = err_q;
  assign data_output_o = work_q;

endmodule
